player_sequencer: RTL and testbench
===================================

# player_sequencer

Playback controller for the music player. It sequences the current-address ASM (the block with `count`, seek pulses, `reset` and `prox_musica`) and owns the song index, play/pause/stop state and seek-button gating. It sits between the debounced button front end and the address ASM/ROM: it turns button pulses into registered single-cycle control pulses and reacts to end-of-song.

## Interface
Parameters:
- `NUM_SONGS`, default 4: number of songs in ROM. Must be 2..2**SONG_W.
- `SONG_W`, default 2: width of `song_idx`.
- `RESET_CYCLES`, default 2: number of cycles `addr_reset` is held on a song change. Must be ≥1.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: async active-high reset.
- `btn_play` in 1: play/pause toggle pulse, one cycle, debounced upstream.
- `btn_next`, `btn_prev` in 1 each: next/previous song pulses.
- `btn_fwd10`, `btn_back10`, `btn_fwd30`, `btn_back30` in 1 each: seek request pulses.
- `sample_tick` in 1: one-cycle pulse at the sample rate.
- `song_end` in 1: end-of-song from the address ASM (`prox_musica`).
- `count` out 1: address-advance enable to the address ASM.
- `passa_10s`, `volta_10s`, `passa_30s`, `volta_30s` out 1 each: one-cycle seek pulses to the address ASM.
- `addr_reset` out 1: resets the address ASM to the song start.
- `song_idx` out SONG_W: current song, used by the ROM base-address mux.
- `playing` out 1: high in PLAY.
- `busy` out 1: high in CHANGE.

## Operation
States: STOP, PLAY, PAUSE, CHANGE. CHANGE stores a return state `ret` (STOP, PLAY or PAUSE).

- **Reset:** state=STOP, song_idx=0, and every output is 0.
- **STOP:**
  - `btn_play` → PLAY.
  - `btn_next`/`btn_prev` → CHANGE with ret=STOP.
  - Seeks are ignored.
- **PLAY:**
  - `btn_play` → PAUSE.
  - `btn_next`/`btn_prev` → CHANGE with ret=PLAY.
  - Seeks are forwarded.
  - `song_end` → CHANGE (see Configuration).
- **PAUSE:**
  - `btn_play` → PLAY.
  - Next/prev → CHANGE with ret=PAUSE.
  - Seeks are forwarded, so the address may move while paused.
  - `song_end` is ignored.
- **CHANGE:**
  - `song_idx` updates on entry.
  - `addr_reset` is held for exactly RESET_CYCLES cycles, then the block goes to `ret`.
  - All button inputs and `song_end` are ignored.
- **Song index arithmetic:** next: idx==NUM_SONGS-1 → 0, else idx+1. Prev: idx==0 → NUM_SONGS-1, else idx-1.
- **Simultaneous events (priority, one action per cycle):** next > prev > song_end > play > seek. Among seeks: fwd10 > back10 > fwd30 > back30. Lower-priority requests in the same cycle are dropped, not queued.
- **`count`:** `sample_tick` registered and gated by state==PLAY. It is never high in STOP, PAUSE or CHANGE.

## Timing
- All outputs are registered. An input pulse sampled on rising edge n produces its response from edge n+1.
- Seek pulses are exactly one cycle wide.
- `count` lags `sample_tick` by one cycle.
- Song change, event sampled at edge n:
  - `song_idx` and `addr_reset` go high at n+1.
  - `busy`=1 and `addr_reset`=1 for cycles n+1 .. n+RESET_CYCLES.
  - The `ret` state is active at n+RESET_CYCLES+1.
- `playing` follows state with the same 1-cycle latency.
- Async `reset` mid-CHANGE aborts immediately. `addr_reset` drops and `song_idx` returns to 0 without waiting for a clock.
- `song_end` held high for several cycles causes only one change, because CHANGE ignores it. After CHANGE, `song_end` from the old address is already low, since `addr_reset` cleared the ASM.

## Configuration
- **`PLAYER_AUTOADVANCE_EN` defined:** `song_end` in PLAY advances song_idx as for next, with ret=PLAY, so playback continues into the next song (wrapping at the last song).
- **Undefined:** `song_end` in PLAY keeps song_idx, enters CHANGE with ret=STOP, and the player stops at the start of the same song.

## Test plan
- **Reset then play:** assert reset, release it, pulse `btn_play`, and drive `sample_tick` every 10 cycles → `playing`=1 and `count` pulses 1 cycle after each tick. Pulse play again → `count` stays 0.
- **Seek gating:** in STOP, pulse `btn_back10` → no `volta_10s`. In PLAY, pulse `btn_fwd30` → `passa_30s` is high for exactly 1 cycle, 1 cycle later. Assert `btn_fwd10`+`btn_back30` together → only `passa_10s`.
- **Wrap:**
  - With NUM_SONGS=4 at idx 3, `btn_next` → idx 0.
  - At idx 0, `btn_prev` → idx 3.
  - `addr_reset` and `busy` are high for exactly 2 cycles, then the block returns to the prior state.
- **End of song:**
  - In PLAY at idx 1, pulse `song_end` → with `PLAYER_AUTOADVANCE_EN`, idx 2 and `playing`=1 after CHANGE.
  - Without it, idx 1 and STOP.
  - In PAUSE, `song_end` does nothing.
- **Priority/CHANGE lockout:** `btn_next`+`song_end`+`btn_play` in the same cycle → one increment and state unchanged afterwards. Pulsing `btn_play` and `btn_next` during CHANGE → ignored.
- **Async reset mid-CHANGE:** assert reset between clock edges while `addr_reset`=1 → all outputs 0 and idx 0 immediately. Release → STOP.

Source files
------------

// File: rtl/player_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : player_sequencer
// Brief    : Playback controller for the music player. Owns the song index
//            and the play/pause/stop state. Turns button pulses into
//            registered control pulses for the address ASM.
//            Optional build macro: PLAYER_AUTOADVANCE_EN. When defined, an
//            end-of-song during play moves on to the next song.
// Revision : 1.0 - initial release
// ============================================================================
module player_sequencer #(
    parameter int NUM_SONGS    = 4,
    parameter int SONG_W       = 2,
    parameter int RESET_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_play,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              btn_fwd10,
    input  logic              btn_back10,
    input  logic              btn_fwd30,
    input  logic              btn_back30,
    input  logic              sample_tick,
    input  logic              song_end,
    output logic              count,
    output logic              passa_10s,
    output logic              volta_10s,
    output logic              passa_30s,
    output logic              volta_30s,
    output logic              addr_reset,
    output logic [SONG_W-1:0] song_idx,
    output logic              playing,
    output logic              busy
);

    localparam logic [1:0] c_ST_STOP   = 2'd0;
    localparam logic [1:0] c_ST_PLAY   = 2'd1;
    localparam logic [1:0] c_ST_PAUSE  = 2'd2;
    localparam logic [1:0] c_ST_CHANGE = 2'd3;

    // The counter holds the number of CHANGE cycles still to come after the current one.
    localparam int                 c_CNT_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(RESET_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [SONG_W-1:0]  c_LAST     = SONG_W'(NUM_SONGS - 1);
    localparam logic [SONG_W-1:0]  c_IDX_ZERO = '0;
    localparam logic [SONG_W-1:0]  c_IDX_ONE  = SONG_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         r_ret;
    logic [c_CNT_W-1:0] r_cnt;
    logic [SONG_W-1:0]  r_song_idx;
    logic               r_count;
    logic               r_passa_10s;
    logic               r_volta_10s;
    logic               r_passa_30s;
    logic               r_volta_30s;
    logic               r_addr_reset;
    logic               r_playing;
    logic               r_busy;

    logic [1:0]         w_state_nxt;
    logic [1:0]         w_ret_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [SONG_W-1:0]  w_idx_nxt;
    logic [SONG_W-1:0]  w_idx_inc;
    logic [SONG_W-1:0]  w_idx_dec;
    logic               w_seek_en;

    assign w_idx_inc = (r_song_idx == c_LAST)     ? c_IDX_ZERO : r_song_idx + c_IDX_ONE;
    assign w_idx_dec = (r_song_idx == c_IDX_ZERO) ? c_LAST     : r_song_idx - c_IDX_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_song_idx;
        w_seek_en   = 1'b0;
        if (r_state == c_ST_CHANGE) begin
            if (r_cnt == c_CNT_ZERO) begin
                w_state_nxt = r_ret;
            end else begin
                w_cnt_nxt = r_cnt - c_CNT_ONE;
            end
        end else if (btn_next) begin
            w_idx_nxt   = w_idx_inc;
            w_ret_nxt   = r_state;
            w_cnt_nxt   = c_CNT_LOAD;
            w_state_nxt = c_ST_CHANGE;
        end else if (btn_prev) begin
            w_idx_nxt   = w_idx_dec;
            w_ret_nxt   = r_state;
            w_cnt_nxt   = c_CNT_LOAD;
            w_state_nxt = c_ST_CHANGE;
        end else if (song_end && (r_state == c_ST_PLAY)) begin
`ifdef PLAYER_AUTOADVANCE_EN
            w_idx_nxt   = w_idx_inc;
            w_ret_nxt   = c_ST_PLAY;
`else
            w_ret_nxt   = c_ST_STOP;
`endif
            w_cnt_nxt   = c_CNT_LOAD;
            w_state_nxt = c_ST_CHANGE;
        end else if (btn_play) begin
            w_state_nxt = (r_state == c_ST_PLAY) ? c_ST_PAUSE : c_ST_PLAY;
        end else begin
            w_seek_en = (r_state != c_ST_STOP);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_STOP;
            r_ret        <= c_ST_STOP;
            r_cnt        <= c_CNT_ZERO;
            r_song_idx   <= c_IDX_ZERO;
            r_count      <= 1'b0;
            r_passa_10s  <= 1'b0;
            r_volta_10s  <= 1'b0;
            r_passa_30s  <= 1'b0;
            r_volta_30s  <= 1'b0;
            r_addr_reset <= 1'b0;
            r_playing    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ret        <= w_ret_nxt;
            r_cnt        <= w_cnt_nxt;
            r_song_idx   <= w_idx_nxt;
            // Gate on the next state so count can never coincide with a non-PLAY state.
            r_count      <= sample_tick && (w_state_nxt == c_ST_PLAY);
            r_passa_10s  <= w_seek_en && btn_fwd10;
            r_volta_10s  <= w_seek_en && !btn_fwd10 && btn_back10;
            r_passa_30s  <= w_seek_en && !btn_fwd10 && !btn_back10 && btn_fwd30;
            r_volta_30s  <= w_seek_en && !btn_fwd10 && !btn_back10 && !btn_fwd30 && btn_back30;
            r_addr_reset <= (w_state_nxt == c_ST_CHANGE);
            r_playing    <= (w_state_nxt == c_ST_PLAY);
            r_busy       <= (w_state_nxt == c_ST_CHANGE);
        end
    end

    assign count      = r_count;
    assign passa_10s  = r_passa_10s;
    assign volta_10s  = r_volta_10s;
    assign passa_30s  = r_passa_30s;
    assign volta_30s  = r_volta_30s;
    assign addr_reset = r_addr_reset;
    assign song_idx   = r_song_idx;
    assign playing    = r_playing;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_player_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_sequencer
// Brief    : Self-checking bench for player_sequencer. Directed scenarios and a
//            random run are compared against a cycle-stamped behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_player_sequencer;

    localparam int c_N = 4;
    localparam int c_W = 2;
    localparam int c_R = 2;

    localparam logic [8:0] c_K_PLAY = 9'h001;
    localparam logic [8:0] c_K_NEXT = 9'h002;
    localparam logic [8:0] c_K_PREV = 9'h004;
    localparam logic [8:0] c_K_F10  = 9'h008;
    localparam logic [8:0] c_K_B10  = 9'h010;
    localparam logic [8:0] c_K_F30  = 9'h020;
    localparam logic [8:0] c_K_B30  = 9'h040;
    localparam logic [8:0] c_K_TICK = 9'h080;
    localparam logic [8:0] c_K_END  = 9'h100;
    localparam logic [8:0] c_K_NONE = 9'h000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_play = 1'b0, btn_next = 1'b0, btn_prev = 1'b0;
    logic btn_fwd10 = 1'b0, btn_back10 = 1'b0, btn_fwd30 = 1'b0, btn_back30 = 1'b0;
    logic sample_tick = 1'b0, song_end = 1'b0;
    logic count, passa_10s, volta_10s, passa_30s, volta_30s, addr_reset, playing, busy;
    logic [c_W-1:0] song_idx;

    int checks = 0;
    int failures = 0;

    // Model: mode 0=stop 1=play 2=pause 3=changing; a change ends at cycle stamp m_end.
    int m_mode, m_ret, m_idx, m_cyc, m_end;
    bit e_count, e_p10, e_v10, e_p30, e_v30;

    player_sequencer #(.NUM_SONGS(c_N), .SONG_W(c_W), .RESET_CYCLES(c_R)) dut (
        .clk(clk), .reset(reset),
        .btn_play(btn_play), .btn_next(btn_next), .btn_prev(btn_prev),
        .btn_fwd10(btn_fwd10), .btn_back10(btn_back10),
        .btn_fwd30(btn_fwd30), .btn_back30(btn_back30),
        .sample_tick(sample_tick), .song_end(song_end),
        .count(count), .passa_10s(passa_10s), .volta_10s(volta_10s),
        .passa_30s(passa_30s), .volta_30s(volta_30s),
        .addr_reset(addr_reset), .song_idx(song_idx),
        .playing(playing), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_mode = 0; m_ret = 0; m_idx = 0; m_end = 0;
        e_count = 0; e_p10 = 0; e_v10 = 0; e_p30 = 0; e_v30 = 0;
    endtask

    task automatic model_step(input logic [8:0] v);
        e_p10 = 0; e_v10 = 0; e_p30 = 0; e_v30 = 0;
        m_cyc++;
        if (m_mode == 3) begin
            if (m_cyc == m_end) m_mode = m_ret;
        end else if (v[1]) begin
            m_idx = (m_idx + 1) % c_N; m_ret = m_mode; m_mode = 3; m_end = m_cyc + c_R;
        end else if (v[2]) begin
            m_idx = (m_idx + c_N - 1) % c_N; m_ret = m_mode; m_mode = 3; m_end = m_cyc + c_R;
        end else if (v[8] && m_mode == 1) begin
`ifdef PLAYER_AUTOADVANCE_EN
            m_idx = (m_idx + 1) % c_N; m_ret = 1;
`else
            m_ret = 0;
`endif
            m_mode = 3; m_end = m_cyc + c_R;
        end else if (v[0]) begin
            m_mode = (m_mode == 1) ? 2 : 1;
        end else if (m_mode != 0) begin
            if (v[3]) e_p10 = 1;
            else if (v[4]) e_v10 = 1;
            else if (v[5]) e_p30 = 1;
            else if (v[6]) e_v30 = 1;
        end
        e_count = v[7] && (m_mode == 1);
    endtask

    // Drive one cycle of inputs, step the model at the edge, settle 1 time unit after.
    task automatic drive(input logic [8:0] v);
        btn_play = v[0]; btn_next = v[1]; btn_prev = v[2];
        btn_fwd10 = v[3]; btn_back10 = v[4]; btn_fwd30 = v[5]; btn_back30 = v[6];
        sample_tick = v[7]; song_end = v[8];
        @(posedge clk);
        if (reset) model_reset();
        else model_step(v);
        #1;
    endtask

    function automatic logic [9:0] exp_vec();
        logic [c_W-1:0] idx;
        idx = m_idx[c_W-1:0];
        return {e_count, e_p10, e_v10, e_p30, e_v30, (m_mode == 3), (m_mode == 3), (m_mode == 1), idx};
    endfunction

    function automatic logic [9:0] dut_vec();
        return {count, passa_10s, volta_10s, passa_30s, volta_30s, addr_reset, busy, playing, song_idx};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        drive(c_K_PLAY | c_K_NEXT);
        drive(c_K_NONE);
        checks++;
        if (dut_vec() !== 10'h0) begin
            failures++; $display("FAIL reset_outputs: got %h expected 000", dut_vec());
        end
        reset = 1'b0;
        drive(c_K_F10);
        checks++;
        if ({playing, busy, passa_10s, song_idx} !== 5'b0) begin
            failures++; $display("FAIL reset_release_stop: got %b expected 00000", {playing, busy, passa_10s, song_idx});
        end
    endtask

    task automatic test_play_count();
        drive(c_K_PLAY);
        checks++;
        if (playing !== 1'b1) begin failures++; $display("FAIL play_enter: playing=%b expected 1", playing); end
        for (int i = 0; i < 30; i++) begin
            drive((i % 10 == 0) ? c_K_TICK : c_K_NONE);
            checks++;
            if (count !== (i % 10 == 0)) begin
                failures++; $display("FAIL count_follow i=%0d: got %b expected %b", i, count, (i % 10 == 0));
            end
        end
        drive(c_K_PLAY);
        checks++;
        if (playing !== 1'b0) begin failures++; $display("FAIL pause_enter: playing=%b expected 0", playing); end
        drive(c_K_TICK);
        checks++;
        if (count !== 1'b0) begin failures++; $display("FAIL count_paused: got %b expected 0", count); end
        drive(c_K_NONE);
    endtask

    task automatic test_seek();
        reset = 1'b1; drive(c_K_NONE); reset = 1'b0; drive(c_K_NONE);
        drive(c_K_B10);
        checks++;
        if (volta_10s !== 1'b0) begin failures++; $display("FAIL seek_stop_ignored: volta_10s=%b expected 0", volta_10s); end
        drive(c_K_PLAY);
        drive(c_K_F30);
        checks++;
        if (passa_30s !== 1'b1) begin failures++; $display("FAIL seek_fwd30: passa_30s=%b expected 1", passa_30s); end
        drive(c_K_NONE);
        checks++;
        if (passa_30s !== 1'b0) begin failures++; $display("FAIL seek_fwd30_width: passa_30s=%b expected 0", passa_30s); end
        drive(c_K_F10 | c_K_B30);
        checks++;
        if ({passa_10s, volta_30s} !== 2'b10) begin
            failures++; $display("FAIL seek_priority: {passa_10s,volta_30s}=%b expected 10", {passa_10s, volta_30s});
        end
        drive(c_K_NONE);
    endtask

    task automatic test_wrap();
        drive(c_K_PREV);
        checks++;
        if ({song_idx, addr_reset, busy} !== {2'd3, 2'b11}) begin
            failures++; $display("FAIL wrap_prev: idx=%0d addr_reset=%b busy=%b expected 3 1 1", song_idx, addr_reset, busy);
        end
        drive(c_K_NONE);
        checks++;
        if ({addr_reset, busy} !== 2'b11) begin
            failures++; $display("FAIL change_hold: addr_reset=%b busy=%b expected 1 1", addr_reset, busy);
        end
        drive(c_K_NONE);
        checks++;
        if ({addr_reset, busy, playing} !== 3'b001) begin
            failures++; $display("FAIL change_return: addr_reset=%b busy=%b playing=%b expected 0 0 1", addr_reset, busy, playing);
        end
        drive(c_K_NEXT);
        checks++;
        if (song_idx !== 2'd0) begin failures++; $display("FAIL wrap_next: idx=%0d expected 0", song_idx); end
        drive(c_K_NONE); drive(c_K_NONE);
    endtask

    task automatic test_song_end();
        drive(c_K_NEXT); drive(c_K_NONE); drive(c_K_NONE);
        checks++;
        if ({song_idx, playing} !== {2'd1, 1'b1}) begin
            failures++; $display("FAIL end_setup: idx=%0d playing=%b expected 1 1", song_idx, playing);
        end
        drive(c_K_END); drive(c_K_END); drive(c_K_NONE);
        checks++;
`ifdef PLAYER_AUTOADVANCE_EN
        if ({song_idx, playing, busy} !== {2'd2, 1'b1, 1'b0}) begin
            failures++; $display("FAIL end_autoadvance: idx=%0d playing=%b busy=%b expected 2 1 0", song_idx, playing, busy);
        end
        drive(c_K_PLAY);
`else
        if ({song_idx, playing, busy} !== {2'd1, 1'b0, 1'b0}) begin
            failures++; $display("FAIL end_stop: idx=%0d playing=%b busy=%b expected 1 0 0", song_idx, playing, busy);
        end
        drive(c_K_PLAY); drive(c_K_PLAY);
`endif
        drive(c_K_END);
        checks++;
        if ({busy, playing, song_idx} !== {2'b00, m_idx[c_W-1:0]}) begin
            failures++; $display("FAIL end_paused_ignored: busy=%b playing=%b idx=%0d expected 0 0 %0d", busy, playing, song_idx, m_idx);
        end
        drive(c_K_NONE);
    endtask

    task automatic test_priority();
        int k;
        k = m_idx;
        drive(c_K_NEXT | c_K_END | c_K_PLAY);
        checks++;
        if ({song_idx, busy} !== {2'((k + 1) % c_N), 1'b1}) begin
            failures++; $display("FAIL prio_next: idx=%0d busy=%b expected %0d 1", song_idx, busy, (k + 1) % c_N);
        end
        drive(c_K_PLAY | c_K_NEXT);
        drive(c_K_NONE);
        checks++;
        if ({song_idx, busy, playing} !== {2'((k + 1) % c_N), 2'b00}) begin
            failures++; $display("FAIL change_lockout: idx=%0d busy=%b playing=%b expected %0d 0 0", song_idx, busy, playing, (k + 1) % c_N);
        end
        drive(c_K_F10);
        checks++;
        if (passa_10s !== 1'b1) begin failures++; $display("FAIL prio_ret_pause: passa_10s=%b expected 1", passa_10s); end
        drive(c_K_NONE);
    endtask

    task automatic test_async_reset();
        drive(c_K_NEXT);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== 10'h0) begin
            failures++; $display("FAIL async_reset: got %h expected 000", dut_vec());
        end
        drive(c_K_NONE);
        reset = 1'b0;
        drive(c_K_B10);
        checks++;
        if ({playing, busy, volta_10s, song_idx} !== 5'b0) begin
            failures++; $display("FAIL async_release_stop: got %b expected 00000", {playing, busy, volta_10s, song_idx});
        end
    endtask

    task automatic test_random();
        logic [8:0] v;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 7; b++) v[b] = ($urandom_range(0, 11) == 0);
            v[7] = ($urandom_range(0, 3) == 0);
            v[8] = ($urandom_range(0, 15) == 0);
            drive(v);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++; $display("FAIL random cycle=%0d: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        m_cyc = 0;
        model_reset();
        test_reset();
        test_play_count();
        test_seek();
        test_wrap();
        test_song_end();
        test_priority();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
